// File: rtl/aes_job_ctrl.sv
// rtl/aes_job_ctrl.sv - job sequencer, in-flight tracker and result FIFO for the AES datapath
//
// Purpose
//   Accepts tagged encrypt/decrypt/key-load jobs, sequences key expansion,
//   issues data blocks into the fixed-latency enc/dec pipelines, picks the
//   per-job result when it emerges and queues it in an output FIFO.
//
// Ports
//   clk, n_rst                 clock, synchronous active-low reset
//   in_valid/in_ready          job handshake
//   in_key_op, in_ed_sel       job kind (key load / data) and mode (1 = encrypt)
//   in_data, in_key, in_tag    job payload
//   kx_start, kx_key, kx_done  key expansion request / key / completion pulse
//   pipe_valid/ed_sel/data     registered issue into the enc/dec pipelines
//   pipe_res_e, pipe_res_d     pipeline outputs, LAT cycles after pipe_valid
//   out_valid/ready/data/tag   result FIFO head and downstream handshake
//   out_err                    data job rejected for lack of a key (data = 0)
//   key_loaded, busy           status

module aes_job_ctrl #(
  parameter int DATA_W = 129,
  parameter int KEY_W  = 128,
  parameter int TAG_W  = 4,
  parameter int LAT    = 11,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_key_op,
  input  logic              in_ed_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              kx_start,
  output logic [KEY_W-1:0]  kx_key,
  input  logic              kx_done,
  output logic              pipe_valid,
  output logic              pipe_ed_sel,
  output logic [DATA_W-1:0] pipe_data,
  input  logic [DATA_W-1:0] pipe_res_e,
  input  logic [DATA_W-1:0] pipe_res_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              key_loaded,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0]   CREDIT   = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    DRAIN   = 2'd2,
    KEY_EXP = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   kx_start_nxt;

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             accepting;
  logic             credit_ok;
  logic             accept;
  logic             key_acc;
  logic             data_acc;
  logic             data_acc_ready;
  logic             data_acc_idle;

  logic [TAG_W-1:0] pipe_tag;

  // Per-job side band that rides alongside the enc/dec pipelines.
  logic [LAT-1:0]   sr_v;
  logic [LAT-1:0]   sr_e;
  logic [TAG_W-1:0] sr_tag [LAT];

  // Rejected (no key) data job waiting one cycle for its FIFO slot.
  logic             err_v;
  logic [TAG_W-1:0] err_tag;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic [TAG_W-1:0]  push_tag;
  logic              push_err;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DEPTH-1:0]  err_mem;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Credit: every accepted data job owns a FIFO slot from acceptance until
  // it is popped, so pushes can never overflow the FIFO.
  assign accepting = (state == IDLE) || (state == READY);
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < CREDIT;
  assign in_ready  = n_rst && accepting && credit_ok;

  assign accept         = in_valid && in_ready;
  assign key_acc        = accept && in_key_op;
  assign data_acc       = accept && !in_key_op;
  assign data_acc_ready = data_acc && (state == READY);
  assign data_acc_idle  = data_acc && (state == IDLE);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      kx_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      kx_start <= kx_start_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt    = state;
    kx_start_nxt = 1'b0;
    case (state)
      IDLE, READY: begin
        if (key_acc) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The old key must stay valid until every in-flight job is pushed.
        if ((inflight == '0) && !pipe_valid) begin
          kx_start_nxt = 1'b1;
          state_nxt    = KEY_EXP;
        end
      end
      KEY_EXP: begin
        if (kx_done) state_nxt = READY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      kx_key     <= '0;
      key_loaded <= 1'b0;
    end else begin
      if (key_acc) kx_key <= in_key;
      if (kx_start_nxt) begin
        key_loaded <= 1'b0;
      end else if ((state == KEY_EXP) && kx_done) begin
        key_loaded <= 1'b1;
      end
    end
  end

  // Issue register into the pipelines.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pipe_valid  <= 1'b0;
      pipe_ed_sel <= 1'b0;
      pipe_data   <= '0;
      pipe_tag    <= '0;
    end else begin
      pipe_valid <= data_acc_ready;
      if (data_acc_ready) begin
        pipe_ed_sel <= in_ed_sel;
        pipe_data   <= in_data;
        pipe_tag    <= in_tag;
      end
    end
  end

  // Side-band shift register: stage LAT-1 lines up with the cycle in which
  // the pipeline result for that job is present on pipe_res_e/pipe_res_d.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr_v <= '0;
      sr_e <= '0;
      for (int i = 0; i < LAT; i++) sr_tag[i] <= '0;
      err_v   <= 1'b0;
      err_tag <= '0;
    end else begin
      sr_v[0]   <= pipe_valid;
      sr_e[0]   <= pipe_ed_sel;
      sr_tag[0] <= pipe_tag;
      for (int i = 1; i < LAT; i++) begin
        sr_v[i]   <= sr_v[i-1];
        sr_e[i]   <= sr_e[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
      err_v <= data_acc_idle;
      if (data_acc_idle) err_tag <= in_tag;
    end
  end

  // Error pushes only happen in IDLE, where nothing can be in flight, so the
  // two push sources never collide.
  assign push      = err_v || sr_v[LAT-1];
  assign push_err  = err_v;
  assign push_tag  = err_v ? err_tag : sr_tag[LAT-1];
  assign push_data = err_v ? '0 : (sr_e[LAT-1] ? pipe_res_e : pipe_res_d);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      inflight <= '0;
    end else begin
      case ({data_acc, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Output FIFO
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = data_mem[rd_ptr];
  assign out_tag   = tag_mem[rd_ptr];
  assign out_err   = err_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
      err_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        tag_mem[wr_ptr]  <= push_tag;
        err_mem[wr_ptr]  <= push_err;
        wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign busy = !accepting || (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_aes_job_ctrl.sv
// tb/tb_aes_job_ctrl.sv - randomized self-checking bench for aes_job_ctrl
//
// Purpose
//   Drives aes_job_ctrl with directed and random jobs, models the enc/dec
//   pipelines as LAT-cycle delays of simple invertible functions and
//   compares the emitted results against a queue-based reference model.

module tb_aes_job_ctrl;

  localparam int DATA_W = 129;
  localparam int KEY_W  = 128;
  localparam int TAG_W  = 4;
  localparam int LAT    = 4;
  localparam int DEPTH  = 4;
  localparam int RW     = 1 + TAG_W + DATA_W;
  localparam logic [DATA_W-1:0] ENC_MASK = {1'b1, 128'hA5C3_0F96_3C5A_9E17_D24B_6E81_F00D_5EED};

  typedef logic [RW-1:0] res_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_key_op;
  logic              in_ed_sel;
  logic [DATA_W-1:0] in_data;
  logic [KEY_W-1:0]  in_key;
  logic [TAG_W-1:0]  in_tag;
  logic              kx_start;
  logic [KEY_W-1:0]  kx_key;
  logic              kx_done;
  logic              pipe_valid;
  logic              pipe_ed_sel;
  logic [DATA_W-1:0] pipe_data;
  logic [DATA_W-1:0] pipe_res_e;
  logic [DATA_W-1:0] pipe_res_d;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic              key_loaded;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_job_ctrl #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key_op(in_key_op),
    .in_ed_sel(in_ed_sel), .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
    .kx_start(kx_start), .kx_key(kx_key), .kx_done(kx_done),
    .pipe_valid(pipe_valid), .pipe_ed_sel(pipe_ed_sel), .pipe_data(pipe_data),
    .pipe_res_e(pipe_res_e), .pipe_res_d(pipe_res_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .key_loaded(key_loaded), .busy(busy)
  );

  function automatic logic [DATA_W-1:0] f_enc(input logic [DATA_W-1:0] x);
    return x ^ ENC_MASK;
  endfunction

  function automatic logic [DATA_W-1:0] f_dec(input logic [DATA_W-1:0] x);
    return {x[DATA_W-2:0], x[DATA_W-1]};
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Environment: fixed-latency enc/dec pipelines.
  logic [DATA_W-1:0] dly [LAT];
  always @(posedge clk) begin
    dly[0] <= pipe_data;
    for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
  end
  assign pipe_res_e = f_enc(dly[LAT-1]);
  assign pipe_res_d = f_dec(dly[LAT-1]);

  // Downstream ready: either task-driven or random.
  logic rand_rdy = 1'b0;
  logic ready_tb;
  logic rr = 1'b0;
  always @(posedge clk) rr <= 1'($urandom_range(0, 1));
  assign out_ready = rand_rdy ? rr : ready_tb;

  // Key expansion responder.
  logic auto_kx = 1'b1;
  int   late_req = 0;
  initial begin
    int late_srv;
    late_srv = 0;
    kx_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (n_rst && kx_start && auto_kx) begin
        repeat (3) @(posedge clk);
        #1 kx_done = 1'b1;
        @(posedge clk);
        #1 kx_done = 1'b0;
      end else if (late_req != late_srv) begin
        late_srv++;
        @(posedge clk);
        #1 kx_done = 1'b1;
        @(posedge clk);
        #1 kx_done = 1'b0;
      end
    end
  end

  // Reference model and observation: expected results are queued in
  // acceptance order, observed results in pop order.
  res_t             exp_q[$];
  res_t             got_q[$];
  logic             key_m = 1'b0;
  int               kx_cnt = 0;
  int               pv_cnt = 0;
  int               kx_bad = 0;
  int               last_data_acc_cyc = 0;
  int               kx_start_cyc = 0;
  logic [KEY_W-1:0] kx_key_seen = '0;

  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete();
      got_q.delete();
      key_m <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (in_key_op) begin
          key_m <= 1'b1;
        end else begin
          last_data_acc_cyc <= cyc;
          if (key_m) exp_q.push_back({1'b0, in_tag, in_ed_sel ? f_enc(in_data) : f_dec(in_data)});
          else       exp_q.push_back({1'b1, in_tag, {DATA_W{1'b0}}});
        end
      end
      if (out_valid && out_ready) got_q.push_back({out_err, out_tag, out_data});
      if (kx_start) begin
        kx_cnt       <= kx_cnt + 1;
        kx_start_cyc <= cyc;
        kx_key_seen  <= kx_key;
      end
      if (kx_done && (kx_key !== kx_key_seen)) kx_bad <= kx_bad + 1;
      if (pipe_valid) pv_cnt <= pv_cnt + 1;
    end
  end

  // Present one job (called just after a posedge) and hold it until accepted
  // or the budget expires; returns just after the following posedge.
  task automatic offer(input logic key_op, input logic ed, input logic [DATA_W-1:0] d,
                       input logic [KEY_W-1:0] k, input logic [TAG_W-1:0] t,
                       input int budget, output logic ok);
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_key_op = key_op;
    in_ed_sel = ed;
    in_data   = d;
    in_key    = k;
    in_tag    = t;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output logic done);
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && (got_q.size() == exp_q.size())) done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_key_op = 1'b0; in_ed_sel = 1'b0;
    in_data = '0; in_key = '0; in_tag = '0; ready_tb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, kx_start, pipe_valid, pipe_ed_sel, out_valid, out_err, key_loaded, busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {in_ready, kx_start, pipe_valid, pipe_ed_sel, out_valid, out_err, key_loaded, busy});
    end
    checks++;
    if ({kx_key, pipe_data, out_data, out_tag} !== '0) begin
      errors++;
      $display("FAIL reset_buses: kx_key %h pipe_data %h out_data %h out_tag %h want all 0",
               kx_key, pipe_data, out_data, out_tag);
    end
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: in_ready %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_no_key();
    logic ok, done;
    int   pv0, s;
    res_t want;
    pv0  = pv_cnt;
    s    = exp_q.size();
    want = {1'b1, 4'd3, {DATA_W{1'b0}}};
    offer(1'b0, 1'b1, rand_data(), '0, 4'd3, 3, ok);
    wait_drain(40, done);
    checks++;
    if (!(ok && done)) begin
      errors++;
      $display("FAIL no_key_handshake: accepted %b drained %b want 1 1", ok, done);
    end
    checks++;
    if (got_q.size() != s + 1) begin
      errors++;
      $display("FAIL no_key_count: got %0d results want %0d", got_q.size() - s, 1);
    end else begin
      checks++;
      if (got_q[s] !== want) begin
        errors++;
        $display("FAIL no_key_result: got %h want %h", got_q[s], want);
      end
    end
    checks++;
    if (pv_cnt != pv0) begin
      errors++;
      $display("FAIL no_key_pipe: pipe_valid cycles %0d want 0", pv_cnt - pv0);
    end
  endtask

  task automatic test_key_load();
    logic             ok, loaded;
    int               kc0, kb0;
    logic [KEY_W-1:0] k;
    k   = 128'h6265_6b65_795f_3132_3334_3536_3738_652e;
    kc0 = kx_cnt;
    kb0 = kx_bad;
    offer(1'b1, 1'b0, '0, k, 4'd0, 3, ok);
    @(negedge clk);
    checks++;
    if (!ok || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL key_drain_ready: accepted %b in_ready %b want 1 0", ok, in_ready);
    end
    loaded = 1'b0;
    for (int i = 0; i < 30 && !loaded; i++) begin
      @(negedge clk);
      #1;
      if (key_loaded === 1'b1) loaded = 1'b1;
    end
    checks++;
    if (!loaded || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL key_loaded: key_loaded %b in_ready %b want 1 1", key_loaded, in_ready);
    end
    checks++;
    if (kx_cnt - kc0 != 1) begin
      errors++;
      $display("FAIL key_kx_pulses: got %0d want 1", kx_cnt - kc0);
    end
    checks++;
    if (kx_key_seen !== k || kx_bad != kb0) begin
      errors++;
      $display("FAIL key_kx_key: got %h (unstable %0d) want %h", kx_key_seen, kx_bad - kb0, k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_enc();
    logic [DATA_W-1:0] d;
    d = rand_data();
    ready_tb  = 1'b1;
    in_valid  = 1'b1; in_key_op = 1'b0; in_ed_sel = 1'b1; in_data = d; in_tag = 4'd1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL enc_accept: in_ready %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_valid !== 1'b1 || pipe_ed_sel !== 1'b1 || pipe_data !== d) begin
      errors++;
      $display("FAIL enc_issue: pipe_valid %b ed %b data %h want 1 1 %h", pipe_valid, pipe_ed_sel, pipe_data, d);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enc_early: out_valid %b at cycle 5 want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_err, out_tag, out_data} !== {1'b1, 1'b0, 4'd1, f_enc(d)}) begin
      errors++;
      $display("FAIL enc_result: valid %b err %b tag %h data %h want 1 0 1 %h",
               out_valid, out_err, out_tag, out_data, f_enc(d));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic ok1, ok2, done;
    logic [DATA_W-1:0] d2, d5;
    int   s;
    d2 = rand_data();
    d5 = rand_data();
    ready_tb = 1'b1;
    s = exp_q.size();
    offer(1'b0, 1'b1, d2, '0, 4'd2, 1, ok1);
    offer(1'b0, 1'b0, d5, '0, 4'd5, 1, ok2);
    wait_drain(40, done);
    checks++;
    if (!(ok1 && ok2 && done)) begin
      errors++;
      $display("FAIL b2b_handshake: acc %b %b drained %b want 1 1 1", ok1, ok2, done);
    end
    checks++;
    if (got_q.size() != s + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", got_q.size() - s);
    end else begin
      checks++;
      if (got_q[s] !== {1'b0, 4'd2, f_enc(d2)}) begin
        errors++;
        $display("FAIL b2b_first: got %h want %h", got_q[s], {1'b0, 4'd2, f_enc(d2)});
      end
      checks++;
      if (got_q[s+1] !== {1'b0, 4'd5, f_dec(d5)}) begin
        errors++;
        $display("FAIL b2b_second: got %h want %h", got_q[s+1], {1'b0, 4'd5, f_dec(d5)});
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok, done;
    int   s, n_ok;
    ready_tb = 1'b0;
    s    = exp_q.size();
    n_ok = 0;
    for (int j = 0; j < 4; j++) begin
      offer(1'b0, 1'($urandom_range(0, 1)), rand_data(), '0, TAG_W'(j), 2, ok);
      if (ok) n_ok++;
    end
    offer(1'b0, 1'b1, rand_data(), '0, 4'd4, 15, ok);
    @(negedge clk);
    checks++;
    if (n_ok != 4 || ok || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_credit: accepted %0d fifth %b in_ready %b want 4 0 0", n_ok, ok, in_ready);
    end
    checks++;
    if (got_q.size() != s || exp_q.size() != s + 4) begin
      errors++;
      $display("FAIL bp_hold: popped %0d queued %0d want 0 4", got_q.size() - s, exp_q.size() - s);
    end
    @(posedge clk);
    #1 ready_tb = 1'b1;
    n_ok = 0;
    offer(1'b0, 1'b1, rand_data(), '0, 4'd4, 40, ok);
    if (ok) n_ok++;
    offer(1'b0, 1'b0, rand_data(), '0, 4'd5, 40, ok);
    if (ok) n_ok++;
    wait_drain(60, done);
    checks++;
    if (n_ok != 2 || !done || got_q.size() != s + 6) begin
      errors++;
      $display("FAIL bp_resume: accepted %0d drained %b results %0d want 2 1 6", n_ok, done, got_q.size() - s);
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (got_q[s+j] !== exp_q[s+j] || got_q[s+j][DATA_W +: TAG_W] !== TAG_W'(j)) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h want %h", j, got_q[s+j], exp_q[s+j]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic ok, done;
    int   s, n_acc, n_data;
    s = exp_q.size();
    n_acc  = 0;
    n_data = 0;
    rand_rdy = 1'b1;
    for (int j = 0; j < 40; j++) begin
      logic kop;
      kop = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      offer(kop, 1'($urandom_range(0, 1)), rand_data(), {4{$urandom}},
            TAG_W'($urandom_range(0, 15)), 80, ok);
      if (ok) n_acc++;
      if (ok && !kop) n_data++;
    end
    rand_rdy = 1'b0;
    ready_tb = 1'b1;
    wait_drain(200, done);
    checks++;
    if (n_acc != 40 || !done || exp_q.size() != s + n_data) begin
      errors++;
      $display("FAIL rand_flow: accepted %0d drained %b data %0d want 40 1 %0d",
               n_acc, done, exp_q.size() - s, n_data);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d", got_q.size() - s, exp_q.size() - s);
    end else begin
      for (int j = s; j < got_q.size(); j++) begin
        checks++;
        if (got_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL rand_result[%0d]: got %h want %h", j - s, got_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_key_inflight_reset();
    logic ok, seen, done;
    int   s, kc0, n_ok;
    ready_tb = 1'b1;
    auto_kx  = 1'b0;
    s    = exp_q.size();
    kc0  = kx_cnt;
    n_ok = 0;
    for (int j = 0; j < 3; j++) begin
      offer(1'b0, 1'($urandom_range(0, 1)), rand_data(), '0, TAG_W'(j + 8), 1, ok);
      if (ok) n_ok++;
    end
    offer(1'b1, 1'b0, '0, {4{$urandom}}, 4'd0, 1, ok);
    if (ok) n_ok++;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (kx_cnt != kc0) seen = 1'b1;
    end
    checks++;
    if (n_ok != 4 || !seen) begin
      errors++;
      $display("FAIL kinf_start: accepted %0d kx_start seen %b want 4 1", n_ok, seen);
    end
    checks++;
    if (kx_start_cyc - last_data_acc_cyc < LAT + 2) begin
      errors++;
      $display("FAIL kinf_wait: kx_start %0d cycles after last job want >= %0d",
               kx_start_cyc - last_data_acc_cyc, LAT + 2);
    end
    checks++;
    if (got_q.size() != s + 3) begin
      errors++;
      $display("FAIL kinf_results: got %0d want 3", got_q.size() - s);
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (got_q[s+j] !== exp_q[s+j]) begin
          errors++;
          $display("FAIL kinf_result[%0d]: got %h want %h", j, got_q[s+j], exp_q[s+j]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({key_loaded, in_ready, busy} !== 3'b001) begin
      errors++;
      $display("FAIL kinf_keyexp: key_loaded %b in_ready %b busy %b want 0 0 1", key_loaded, in_ready, busy);
    end
    @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, kx_start, pipe_valid, pipe_ed_sel, out_valid, out_err, key_loaded, busy} !== 8'b0 ||
        {kx_key, pipe_data, out_data, out_tag} !== '0) begin
      errors++;
      $display("FAIL kinf_reset: ctrl %b kx_key %h out_data %h want all 0",
               {in_ready, kx_start, pipe_valid, pipe_ed_sel, out_valid, out_err, key_loaded, busy},
               kx_key, out_data);
    end
    @(posedge clk);
    #1 n_rst = 1'b1;
    late_req++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({key_loaded, in_ready, busy} !== 3'b010 || kx_cnt != kc0 + 1) begin
      errors++;
      $display("FAIL kinf_late_done: key_loaded %b in_ready %b busy %b kx_pulses %0d want 0 1 0 1",
               key_loaded, in_ready, busy, kx_cnt - kc0);
    end
    @(posedge clk);
    #1;
    s = exp_q.size();
    offer(1'b0, 1'b1, rand_data(), '0, 4'd9, 3, ok);
    wait_drain(40, done);
    checks++;
    if (!ok || !done || got_q.size() != s + 1 || got_q[s] !== {1'b1, 4'd9, {DATA_W{1'b0}}}) begin
      errors++;
      $display("FAIL kinf_post_reset_err: accepted %b drained %b results %0d want err result tag 9",
               ok, done, got_q.size() - s);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_key();
    test_key_load();
    test_single_enc();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_key_inflight_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
